// File: rtl/prbs_seq_ctrl_pkg.sv
// Shared types and constants for the PRBS-15 sequencer and its datapath.
package prbs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REPEAT,
        PRBS,
        DONE
    } seq_state_t;

    localparam logic [14:0] PRBS15_SEED  = 15'h2ABC;
    localparam int          PRBS15_TAP_A = 14;
    localparam int          PRBS15_TAP_B = 13;
    localparam int          LOAD_BYTES   = 4;

    localparam int NUM_W_DEF = 4;
    localparam int LEN_W_DEF = 16;
    localparam int ERR_W_DEF = 16;

    // x^15 + x^14 + 1, Fibonacci form: shift toward the MSB, feedback into bit 0.
    function automatic logic [14:0] prbs15Next(input logic [14:0] state);
        return {state[13:0], state[PRBS15_TAP_A] ^ state[PRBS15_TAP_B]};
    endfunction

endpackage

// File: rtl/prbs_seq_ctrl_if.sv
// Config handshake and datapath control bundle between host, sequencer and datapath.
interface prbs_seq_ctrl_if
    import prbs_pkg::*;
#(
    parameter int NUM_W = NUM_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int ERR_W = ERR_W_DEF
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [31:0]      cfg_word;
    logic [NUM_W-1:0] cfg_reps;
    logic [LEN_W-1:0] cfg_len;
    logic             abort;
    logic [7:0]       dp_data;
    logic             dp_load;
    logic [NUM_W-1:0] dp_n;
    logic             dp_rep_en;
    logic             dp_prbs_en;
    logic             prbs_in;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output cfg_valid, cfg_word, cfg_reps, cfg_len, abort, prbs_in,
        input  cfg_ready, dp_data, dp_load, dp_n, dp_rep_en, dp_prbs_en,
               busy, done, aborted, err_cnt
    );

    modport slave (
        input  cfg_valid, cfg_word, cfg_reps, cfg_len, abort, prbs_in,
        output cfg_ready, dp_data, dp_load, dp_n, dp_rep_en, dp_prbs_en,
               busy, done, aborted, err_cnt
    );

endinterface

// File: rtl/prbs_seq_ctrl_lfsr.sv
// PRBS-15 generator with enable and synchronous reseed; MSB is the output bit.
module prbs15_lfsr
    import prbs_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic i_en,
    input  logic i_reseed,
    output logic o_msb
);

    logic [14:0] r_state;

    // Reset to the seed rather than zero: an all-zero LFSR never leaves that state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= PRBS15_SEED;
        end else if (i_reseed) begin
            r_state <= PRBS15_SEED;
        end else if (i_en) begin
            r_state <= prbs15Next(r_state);
        end
    end

    assign o_msb = r_state[14];

endmodule

// File: rtl/prbs_seq_ctrl.sv
// PRBS-15 test sequencer: pattern load, word repetition, PRBS emission.
// Define PRBS_CHECK_EN to build the on-board PRBS mismatch counter.
module prbs_seq_ctrl
    import prbs_pkg::*;
#(
    parameter int NUM_W = NUM_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    prbs_seq_ctrl_if.slave bus
);

    localparam int REP_W = NUM_W + 2;
    localparam int CNT_W = (LEN_W > REP_W) ? LEN_W : REP_W;

    seq_state_t       r_state;
    seq_state_t       w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [31:0]      r_word;
    logic [NUM_W-1:0] r_reps;
    logic [LEN_W-1:0] r_len;
    logic             r_aborted;
    logic             w_accept;
    logic             w_abortTake;
    logic             w_cntLast;
    logic [1:0]       w_byteSel;

    assign w_accept    = (r_state == IDLE) && bus.cfg_valid && !bus.abort;
    assign w_abortTake = bus.abort && (r_state != IDLE) && (r_state != DONE);
    assign w_cntLast   = (r_cnt == CNT_W'(1));
    assign w_byteSel   = 2'(r_cnt[1:0] - 2'd1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_word    <= '0;
            r_reps    <= '0;
            r_len     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_aborted <= w_abortTake;
            if (w_accept) begin
                r_word <= bus.cfg_word;
                r_reps <= bus.cfg_reps;
                r_len  <= bus.cfg_len;
            end
        end
    end

    // Each phase reloads the shared down-counter on entry and exits when it reads 1.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        bus.cfg_ready  = 1'b0;
        bus.dp_load    = 1'b0;
        bus.dp_data    = 8'h00;
        bus.dp_rep_en  = 1'b0;
        bus.dp_prbs_en = 1'b0;
        bus.busy       = (r_state != IDLE);
        bus.done       = 1'b0;

        unique case (r_state)
            IDLE: begin
                bus.cfg_ready = !bus.abort;
                if (w_accept) begin
                    w_stateNext = LOAD;
                    w_cntNext   = CNT_W'(LOAD_BYTES);
                end
            end
            LOAD: begin
                bus.dp_load = 1'b1;
                bus.dp_data = r_word[{w_byteSel, 3'b000} +: 8];
                if (w_cntLast) begin
                    if (r_reps != '0) begin
                        w_stateNext = REPEAT;
                        w_cntNext   = CNT_W'({r_reps, 2'b00});
                    end else if (r_len != '0) begin
                        w_stateNext = PRBS;
                        w_cntNext   = CNT_W'(r_len);
                    end else begin
                        w_stateNext = DONE;
                    end
                end
            end
            REPEAT: begin
                bus.dp_rep_en = 1'b1;
                if (w_cntLast) begin
                    if (r_len != '0) begin
                        w_stateNext = PRBS;
                        w_cntNext   = CNT_W'(r_len);
                    end else begin
                        w_stateNext = DONE;
                    end
                end
            end
            PRBS: begin
                bus.dp_prbs_en = 1'b1;
                if (w_cntLast) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase

        if (w_abortTake) begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
        end
    end

    assign bus.aborted = r_aborted;
    assign bus.dp_n    = r_reps;

`ifdef PRBS_CHECK_EN
    logic             r_prbsEnDly;
    logic             w_refMsb;
    logic [ERR_W-1:0] r_errCnt;

    // The datapath returns each PRBS bit one cycle after the enable that produced it.
    prbs15_lfsr u_refLfsr (
        .CLK      (CLK),
        .RST      (RST),
        .i_en     (r_prbsEnDly),
        .i_reseed (w_accept),
        .o_msb    (w_refMsb)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prbsEnDly <= 1'b0;
            r_errCnt    <= '0;
        end else begin
            r_prbsEnDly <= (r_state == PRBS);
            if (w_accept) begin
                r_errCnt <= '0;
            end else if (r_prbsEnDly && (w_refMsb != bus.prbs_in) && (r_errCnt != '1)) begin
                r_errCnt <= r_errCnt + ERR_W'(1);
            end
        end
    end

    assign bus.err_cnt = r_errCnt;
`else
    logic w_unusedPrbsIn;
    assign w_unusedPrbsIn = bus.prbs_in;
    assign bus.err_cnt    = {ERR_W{1'b0}};
`endif

endmodule
